// File: rtl/ibex_ibus_arbiter_pkg.sv
// Shared types and helpers for the two-host instruction bus arbiter.
// Host IDs, host count and address/one-hot helpers.
package ibex_ibus_arbiter_pkg;

  localparam int unsigned IBUS_NUM_HOSTS = 2;
  localparam int unsigned IBUS_AW = 32;
  localparam int unsigned IBUS_DW = 32;

  typedef enum logic {
    IBUS_HOST_PF  = 1'b0,
    IBUS_HOST_AUX = 1'b1
  } ibus_host_e;

  function automatic logic [IBUS_AW-1:0] ibus_word_addr(
    input logic [IBUS_AW-1:0] a
  );
    return a & ~IBUS_AW'(3);
  endfunction

  function automatic logic [IBUS_NUM_HOSTS-1:0] ibus_onehot(
    input ibus_host_e h
  );
    return IBUS_NUM_HOSTS'(1) << h;
  endfunction

endpackage

// File: rtl/ibex_ibus_arbiter_if.sv
// Host-side and memory-side instruction bus signals of the arbiter.
// slave: arbiter view; master: hosts plus memory view.
interface ibex_ibus_arbiter_if;
  import ibex_ibus_arbiter_pkg::*;

  logic [IBUS_NUM_HOSTS-1:0]              host_req_i;
  logic [IBUS_NUM_HOSTS-1:0][IBUS_AW-1:0] host_addr_i;
  logic [IBUS_NUM_HOSTS-1:0]              host_gnt_o;
  logic [IBUS_NUM_HOSTS-1:0]              host_rvalid_o;
  logic [IBUS_DW-1:0]                     host_rdata_o;
  logic                                   host_err_o;

  logic               bus_req_o;
  logic [IBUS_AW-1:0] bus_addr_o;
  logic               bus_gnt_i;
  logic               bus_rvalid_i;
  logic [IBUS_DW-1:0] bus_rdata_i;
  logic               bus_err_i;

  modport slave (
    input  host_req_i,
    input  host_addr_i,
    output host_gnt_o,
    output host_rvalid_o,
    output host_rdata_o,
    output host_err_o,
    output bus_req_o,
    output bus_addr_o,
    input  bus_gnt_i,
    input  bus_rvalid_i,
    input  bus_rdata_i,
    input  bus_err_i
  );

  modport master (
    output host_req_i,
    output host_addr_i,
    input  host_gnt_o,
    input  host_rvalid_o,
    input  host_rdata_o,
    input  host_err_o,
    input  bus_req_o,
    input  bus_addr_o,
    output bus_gnt_i,
    output bus_rvalid_i,
    output bus_rdata_i,
    output bus_err_i
  );

endinterface

// File: rtl/ibex_ibus_id_fifo.sv
// In-order FIFO holding the issuing host ID of each outstanding request.
// Push and pop may coincide, including at full.
module ibex_ibus_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  // at full a coincident pop frees the slot being written
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wptr_d = push_ok ? inc(wptr_q) : wptr_q;
    rptr_d = pop_ok ? inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ibex_ibus_arbiter.sv
// Two-host instruction bus arbiter: round-robin, lock until grant,
// and in-order response routing through an outstanding-ID queue.
module ibex_ibus_arbiter
  import ibex_ibus_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned ResetPrio      = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ibex_ibus_arbiter_if.slave  ibus,
  output logic                busy_o
);

  ibus_host_e sel;
  ibus_host_e head;
  ibus_host_e prio_q, prio_d;
  ibus_host_e lock_id_q, lock_id_d;
  logic       lock_q, lock_d;
  logic       q_full, q_empty;
  logic [0:0] head_raw;
  logic       req_sel;
  logic       gnt_evt;
  logic       rsp_evt;
  logic       lock_drop;

  always_comb begin
    sel = prio_q;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (ibus.host_req_i == 2'b01) begin
      sel = IBUS_HOST_PF;
    end else if (ibus.host_req_i == 2'b10) begin
      sel = IBUS_HOST_AUX;
    end else begin
      sel = prio_q;
    end
  end

  assign req_sel = ibus.host_req_i[sel];
  assign gnt_evt = ibus.bus_req_o & ibus.bus_gnt_i;
  assign rsp_evt = rst_ni & ibus.bus_rvalid_i & ~q_empty;
  assign head    = ibus_host_e'(head_raw);

  assign ibus.bus_req_o  = rst_ni & req_sel & ~q_full;
  assign ibus.bus_addr_o = ibus_word_addr(ibus.host_addr_i[sel]);

  assign ibus.host_gnt_o    = gnt_evt ? ibus_onehot(sel) : '0;
  assign ibus.host_rvalid_o = rsp_evt ? ibus_onehot(head) : '0;
  assign ibus.host_rdata_o  = ibus.bus_rdata_i;
  assign ibus.host_err_o    = ibus.bus_err_i;

  assign busy_o = rst_ni & (~q_empty | ibus.bus_req_o);

  // a locked host that withdraws forfeits its lock
  assign lock_drop = lock_q & ~ibus.host_req_i[lock_id_q];

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    prio_d    = prio_q;
    if (lock_drop || gnt_evt) begin
      lock_d = 1'b0;
    end else if (ibus.bus_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
    if (gnt_evt) begin
      prio_d = ibus_host_e'(~sel);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_id_q <= IBUS_HOST_PF;
      prio_q    <= ibus_host_e'(ResetPrio[0]);
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      prio_q    <= prio_d;
    end
  end

  ibex_ibus_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (1)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_evt),
    .data_i  (sel),
    .pop_i   (rsp_evt),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head_raw)
  );

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(ibus.bus_rvalid_i && q_empty))
        else $warning("ibus_arbiter: bus_rvalid_i with no outstanding ID");
      assert (!lock_drop)
        else $warning("ibus_arbiter: locked host dropped req before gnt");
    end
  end

endmodule

// File: tb/tb_ibex_ibus_arbiter.sv
// Directed bench for ibex_ibus_arbiter with an outstanding-ID scoreboard.
// Expected host IDs are queued at grant and compared at response.
module tb_ibex_ibus_arbiter;
  import ibex_ibus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  logic busy;

  always #5 clk = ~clk;

  ibex_ibus_arbiter_if ifc ();

  ibex_ibus_arbiter #(
    .MaxOutstanding (2),
    .ResetPrio      (0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .ibus   (ifc),
    .busy_o (busy)
  );

  int checks = 0;
  int errors = 0;
  int unsigned sb[$];

  function automatic logic [1:0] oh(input int unsigned h);
    logic [1:0] one;
    one = 2'b01;
    return (h < 2) ? (one << h) : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.host_req_i   = 2'b00;
    ifc.bus_gnt_i    = 1'b0;
    ifc.bus_rvalid_i = 1'b0;
    ifc.bus_rdata_i  = 32'h0;
    ifc.bus_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic exp_rsp(input string tag, input logic [31:0] d);
    int unsigned h;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    h = (sb.size() != 0) ? sb.pop_front() : 2;
    chk({tag, "_rvalid"}, 32'(ifc.host_rvalid_o), 32'(oh(h)));
    chk({tag, "_rdata"}, ifc.host_rdata_o, d);
  endtask

  task automatic give_rsp(input string tag, input logic [31:0] d);
    ifc.host_req_i   = 2'b00;
    ifc.bus_gnt_i    = 1'b0;
    ifc.bus_rvalid_i = 1'b1;
    ifc.bus_rdata_i  = d;
    #1;
    exp_rsp(tag, d);
    tick();
    ifc.bus_rvalid_i = 1'b0;
  endtask

  int unsigned seq [4];
  logic [31:0] haddr [2];

  initial begin
    seq = '{0, 1, 0, 1};
    haddr = '{32'h0000_1000, 32'h0000_2000};
    ifc.host_addr_i = '0;

    // reset: outputs forced low even with live inputs
    rst_ni = 1'b0;
    ifc.host_req_i   = 2'b11;
    ifc.host_addr_i[0] = 32'h104;
    ifc.host_addr_i[1] = 32'h204;
    ifc.bus_gnt_i    = 1'b1;
    ifc.bus_rvalid_i = 1'b1;
    ifc.bus_rdata_i  = 32'h0;
    ifc.bus_err_i    = 1'b0;
    tick();
    #1;
    chk("rst_bus_req", 32'(ifc.bus_req_o), 32'd0);
    chk("rst_gnt", 32'(ifc.host_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(ifc.host_rvalid_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle();
    tick();
    rst_ni = 1'b1;
    tick();
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // single fetch from host 0, unaligned address
    ifc.host_req_i     = 2'b01;
    ifc.host_addr_i[0] = 32'h0000_0102;
    ifc.bus_gnt_i      = 1'b1;
    #1;
    chk("t1_req", 32'(ifc.bus_req_o), 32'd1);
    chk("t1_addr", ifc.bus_addr_o, 32'h0000_0100);
    chk("t1_gnt", 32'(ifc.host_gnt_o), 32'(2'b01));
    sb.push_back(0);
    tick();
    ifc.bus_err_i = 1'b1;
    ifc.host_req_i   = 2'b00;
    ifc.bus_gnt_i    = 1'b0;
    ifc.bus_rvalid_i = 1'b1;
    ifc.bus_rdata_i  = 32'hDEAD_BEEF;
    #1;
    exp_rsp("t1_rsp", 32'hDEAD_BEEF);
    chk("t1_err", 32'(ifc.host_err_o), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    idle();
    #1;
    chk("t1_busy_end", 32'(busy), 32'd0);

    // round robin, responses one cycle behind
    do_reset();
    ifc.host_addr_i[0] = haddr[0];
    ifc.host_addr_i[1] = haddr[1];
    for (int i = 0; i < 5; i++) begin
      ifc.host_req_i   = (i < 4) ? 2'b11 : 2'b00;
      ifc.bus_gnt_i    = (i < 4);
      ifc.bus_rvalid_i = (i > 0);
      ifc.bus_rdata_i  = 32'hA000_0000 + 32'(i);
      #1;
      if (i > 0) exp_rsp($sformatf("rr_rsp%0d", i), 32'hA000_0000 + 32'(i));
      if (i < 4) begin
        chk($sformatf("rr_gnt%0d", i), 32'(ifc.host_gnt_o), 32'(oh(seq[i])));
        chk($sformatf("rr_addr%0d", i), ifc.bus_addr_o, haddr[seq[i]]);
        sb.push_back(seq[i]);
      end
      tick();
    end
    idle();

    // host 1 locked while host 0 has priority
    do_reset();
    ifc.host_addr_i[0] = 32'h0000_1008;
    ifc.host_addr_i[1] = 32'h0000_2004;
    ifc.host_req_i = 2'b10;
    #1;
    chk("lk_addr0", ifc.bus_addr_o, 32'h0000_2004);
    chk("lk_gnt0", 32'(ifc.host_gnt_o), 32'd0);
    tick();
    for (int i = 1; i < 3; i++) begin
      ifc.host_req_i = 2'b11;
      #1;
      chk($sformatf("lk_addr%0d", i), ifc.bus_addr_o, 32'h0000_2004);
      chk($sformatf("lk_req%0d", i), 32'(ifc.bus_req_o), 32'd1);
      tick();
    end
    ifc.bus_gnt_i = 1'b1;
    #1;
    chk("lk_gnt3", 32'(ifc.host_gnt_o), 32'(2'b10));
    sb.push_back(1);
    tick();
    ifc.host_req_i = 2'b01;
    #1;
    chk("lk_gnt4", 32'(ifc.host_gnt_o), 32'(2'b01));
    chk("lk_addr4", ifc.bus_addr_o, 32'h0000_1008);
    sb.push_back(0);
    tick();
    give_rsp("lk_rsp_a", 32'h1111_0001);
    give_rsp("lk_rsp_b", 32'h1111_0002);

    // queue full stall, released one cycle after the pop
    do_reset();
    ifc.host_req_i = 2'b11;
    ifc.bus_gnt_i  = 1'b1;
    #1;
    chk("fl_gnt0", 32'(ifc.host_gnt_o), 32'(2'b01));
    sb.push_back(0);
    tick();
    #1;
    chk("fl_gnt1", 32'(ifc.host_gnt_o), 32'(2'b10));
    sb.push_back(1);
    tick();
    #1;
    chk("fl_req_stall", 32'(ifc.bus_req_o), 32'd0);
    chk("fl_gnt_stall", 32'(ifc.host_gnt_o), 32'd0);
    chk("fl_busy", 32'(busy), 32'd1);
    tick();
    ifc.bus_rvalid_i = 1'b1;
    ifc.bus_rdata_i  = 32'h2222_0000;
    #1;
    chk("fl_req_popcyc", 32'(ifc.bus_req_o), 32'd0);
    chk("fl_gnt_popcyc", 32'(ifc.host_gnt_o), 32'd0);
    exp_rsp("fl_rsp0", 32'h2222_0000);
    tick();
    ifc.bus_rvalid_i = 1'b0;
    #1;
    chk("fl_req_after", 32'(ifc.bus_req_o), 32'd1);
    chk("fl_gnt_after", 32'(ifc.host_gnt_o), 32'(2'b01));
    sb.push_back(0);
    tick();
    give_rsp("fl_rsp1", 32'h2222_0001);
    give_rsp("fl_rsp2", 32'h2222_0002);

    // grant and response together at count 1
    do_reset();
    ifc.host_req_i = 2'b01;
    ifc.bus_gnt_i  = 1'b1;
    #1;
    chk("sm_gnt0", 32'(ifc.host_gnt_o), 32'(2'b01));
    sb.push_back(0);
    tick();
    ifc.host_req_i   = 2'b10;
    ifc.bus_rvalid_i = 1'b1;
    ifc.bus_rdata_i  = 32'h3333_0000;
    #1;
    chk("sm_gnt1", 32'(ifc.host_gnt_o), 32'(2'b10));
    exp_rsp("sm_rsp0", 32'h3333_0000);
    sb.push_back(1);
    tick();
    idle();
    #1;
    chk("sm_busy_cnt1", 32'(busy), 32'd1);
    give_rsp("sm_rsp1", 32'h3333_0001);
    #1;
    chk("sm_busy_end", 32'(busy), 32'd0);

    // reset with two IDs outstanding, then a stray response
    do_reset();
    ifc.host_req_i = 2'b11;
    ifc.bus_gnt_i  = 1'b1;
    tick();
    tick();
    idle();
    #1;
    chk("mr_busy_pre", 32'(busy), 32'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    ifc.bus_rvalid_i = 1'b1;
    ifc.bus_rdata_i  = 32'h4444_0000;
    #1;
    chk("mr_rvalid", 32'(ifc.host_rvalid_o), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    tick();
    idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
